// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the unified memory bus arbiter.
//   arb_state_t : arbiter FSM state (IDLE, REQ, WAIT)
//   arb_owner_t : which port owns the current bus transaction
//   BE_W        : byte-enable width of the data port and the bus
//   STREAK_W    : width of the consecutive-data-grant counter
package mem_arb_pkg;

  localparam int BE_W     = 4;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    I,
    D
  } arb_owner_t;

  // Saturating increment so a long data burst cannot wrap the streak
  // counter back below the fetch-starvation threshold.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] v);
    return (v == '1) ? v : v + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog
//   Transaction timeout counter. Counts every cycle the arbiter is busy
//   (REQ or WAIT) and flags timeout in the cycle where the count reaches
//   TIMEOUT_CYCLES. The count returns to zero while the arbiter is idle.
//   Only instantiated when MEM_BUS_ARBITER_TIMEOUT_EN is defined.
// Ports:
//   clk     in  : clock
//   rst_n   in  : asynchronous active-low reset
//   busy    in  : arbiter is in REQ or WAIT
//   timeout out : limit reached this cycle (combinational)
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // The first busy cycle sees count 0, so the limit is count == TIMEOUT_CYCLES-1.
  assign timeout = busy && (count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!busy || timeout) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single unified memory bus between the instruction-fetch port
//   and the data (load/store) port. One transaction outstanding at a time;
//   data wins arbitration unless it has already taken MAX_D_STREAK grants in
//   a row while a fetch was waiting. A fetch may be flushed while pending or
//   in flight; its response is then swallowed.
//   Optional macro MEM_BUS_ARBITER_TIMEOUT_EN adds a watchdog that completes a
//   stuck transaction after TIMEOUT_CYCLES with zero data and a bus_err_o pulse.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   if_req/if_addr/if_flush            fetch request, address, flush pulse
//   if_ack/if_rdata                    fetch completion pulse and data
//   d_req/d_we/d_addr/d_wdata/d_be     data request fields
//   d_ack/d_rdata                      data completion pulse and load data
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be   bus request (registered)
//   bus_gnt/bus_rvalid/bus_rdata       bus accept and response
//   bus_err_o                          timeout pulse (0 without the macro)
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [BE_W-1:0]   bus_be,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err_o
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state;
  arb_owner_t          owner;
  logic [STREAK_W-1:0] d_streak;
  logic                discard;
  logic                timeout;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .busy   (state != IDLE),
    .timeout(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  assign bus_err_o = timeout;

  // A transaction ends on a response in WAIT or on a forced timeout. A fetch
  // response is dropped if it was flushed earlier (discard) or in this cycle.
  logic              finish;
  logic [DATA_W-1:0] resp_data;

  assign finish    = ((state == WAIT) && bus_rvalid) || timeout;
  assign resp_data = timeout ? '0 : bus_rdata;
  assign if_ack    = finish && (owner == I) && !discard && !if_flush;
  assign d_ack     = finish && (owner == D);
  assign if_rdata  = if_ack ? resp_data : '0;
  assign d_rdata   = d_ack ? resp_data : '0;

  // Arbiter FSM. Bus fields are captured from the winner on the IDLE->REQ
  // edge and held stable until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= NONE;
      d_streak  <= '0;
      discard   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && (!if_req || (d_streak < MAX_STREAK))) begin
            state     <= REQ;
            owner     <= D;
            bus_req   <= 1'b1;
            bus_we    <= d_we;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
            bus_be    <= d_be;
            // The streak only grows while a fetch is actually being held off.
            d_streak  <= if_req ? streak_inc(d_streak) : '0;
          end else if (if_req && !if_flush) begin
            state     <= REQ;
            owner     <= I;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            bus_be    <= '1;
            d_streak  <= '0;
          end
        end
        REQ: begin
          if (timeout) begin
            state   <= IDLE;
            owner   <= NONE;
            bus_req <= 1'b0;
            discard <= 1'b0;
          end else if (bus_gnt) begin
            // Once granted the bus will respond, so a flushed fetch must
            // still wait for its response and then swallow it.
            state   <= WAIT;
            bus_req <= 1'b0;
            if ((owner == I) && if_flush) begin
              discard <= 1'b1;
            end
          end else if ((owner == I) && if_flush) begin
            state   <= IDLE;
            owner   <= NONE;
            bus_req <= 1'b0;
          end
        end
        WAIT: begin
          if (bus_rvalid || timeout) begin
            state   <= IDLE;
            owner   <= NONE;
            discard <= 1'b0;
          end else if ((owner == I) && if_flush) begin
            discard <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          owner   <= NONE;
          bus_req <= 1'b0;
          discard <= 1'b0;
        end
      endcase
    end
  end

  // Requester and bus protocol checks.
  a_d_req_held : assert property (@(posedge clk) disable iff (!rst_n)
    (d_req && !d_ack) |=> d_req);
  a_if_req_held : assert property (@(posedge clk) disable iff (!rst_n)
    (if_req && !if_ack && !if_flush) |=> if_req);
  a_no_rvalid_in_req : assert property (@(posedge clk) disable iff (!rst_n)
    (state == REQ) |-> !bus_rvalid);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter. Expected acknowledgements are queued
//   when a bus response is driven and popped when an ack is observed.
//   Optional macro MEM_BUS_ARBITER_TIMEOUT_EN enables the timeout scenario.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err_o;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_D_STREAK(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } sb_item_t;

  sb_item_t sb[$];
  int       checks = 0;
  int       failures = 0;
  logic     exp_err = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic i_req, input logic [31:0] i_addr,
                               input logic dq, input logic we, input logic [31:0] da,
                               input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    if_req  = i_req;
    if_addr = i_addr;
    d_req   = dq;
    d_we    = we;
    d_addr  = da;
    d_wdata = wd;
    d_be    = be;
  endtask

  // Sample combinational outputs shortly after the falling edge and match
  // any ack against the scoreboard.
  task automatic observe();
    sb_item_t e;
    #1;
    checkOutput("bus_err_o", bus_err_o, exp_err);
    if (!if_ack) checkOutput("if_rdata_zero", if_rdata, 32'd0);
    if (!d_ack)  checkOutput("d_rdata_zero", d_rdata, 32'd0);
    if (if_ack || d_ack) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_ack", {30'd0, d_ack, if_ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("ack_owner", {30'd0, d_ack, if_ack}, e.is_data ? 32'd2 : 32'd1);
        checkOutput("ack_rdata", e.is_data ? d_rdata : if_rdata, e.rdata);
      end
    end
  endtask

  // Zero-wait bus: grant in the REQ cycle, respond in the next cycle.
  task automatic zeroWaitTxn(input logic is_data, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input logic [31:0] rdata, input logic flush_a);
    @(negedge clk);
    bus_gnt  = 1'b1;
    if_flush = flush_a;
    observe();
    checkOutput("bus_req_in_req", bus_req, 1'b1);
    checkOutput("bus_addr", bus_addr, addr);
    checkOutput("bus_we", bus_we, we);
    if (is_data) begin
      checkOutput("bus_wdata", bus_wdata, wdata);
      checkOutput("bus_be", bus_be, be);
    end
    @(negedge clk);
    bus_gnt    = 1'b0;
    if_flush   = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = rdata;
    sb.push_back('{is_data, rdata});
    observe();
    checkOutput("ack_latency", sb.size(), 32'd0);
    checkOutput("bus_req_in_wait", bus_req, 1'b0);
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_bus_req", bus_req, 1'b0);
    checkOutput("rst_bus_we", bus_we, 1'b0);
    checkOutput("rst_bus_addr", bus_addr, 32'd0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
    checkOutput("rst_bus_be", bus_be, 4'd0);
    checkOutput("rst_if_ack", if_ack, 1'b0);
    checkOutput("rst_d_ack", d_ack, 1'b0);
    checkOutput("rst_bus_err", bus_err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // Stray response in IDLE is ignored
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1111_2222;
    observe();
    checkOutput("stray_bus_req", bus_req, 1'b0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    observe();
    checkOutput("stray_still_idle", bus_req, 1'b0);

    // Single fetch, zero-wait
    $display("[TB] single fetch");
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    observe();
    checkOutput("fetch_c0_bus_req", bus_req, 1'b0);
    zeroWaitTxn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    observe();
    checkOutput("fetch_bubble", bus_req, 1'b0);

    // Simultaneous requests: data store first, then fetch
    $display("[TB] simultaneous requests");
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'hF);
    observe();
    zeroWaitTxn(1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'hF, 32'h0000_A5A5, 1'b0);
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    observe();
    checkOutput("simul_bubble", bus_req, 1'b0);
    zeroWaitTxn(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    observe();

    // Starvation guard: four data grants, then the waiting fetch
    $display("[TB] starvation guard");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 32'h4000 + 32'(4 * k), 32'h0, 4'h3);
      observe();
      zeroWaitTxn(1'b1, 1'b0, 32'h4000 + 32'(4 * k), 32'h0, 4'h3, 32'h4000_0000 + 32'(k), 1'b0);
    end
    applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 32'h4010, 32'h0, 4'h3);
    observe();
    zeroWaitTxn(1'b0, 1'b0, 32'h500, 32'h0, 4'h0, 32'h5555_0500, 1'b0);
    // Streak was cleared by the fetch grant, so data wins again
    applyStimulus(1'b1, 32'h504, 1'b1, 1'b0, 32'h4010, 32'h0, 4'h3);
    observe();
    zeroWaitTxn(1'b1, 1'b0, 32'h4010, 32'h0, 4'h3, 32'h4000_0010, 1'b0);
    applyStimulus(1'b1, 32'h504, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    observe();
    zeroWaitTxn(1'b0, 1'b0, 32'h504, 32'h0, 4'h0, 32'h5555_0504, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    observe();

    // Flush in REQ without grant: abort
    $display("[TB] flush paths");
    applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    observe();
    @(negedge clk);
    if_flush = 1'b1;
    observe();
    checkOutput("flush_req_bus_req", bus_req, 1'b1);
    @(negedge clk);
    if_flush = 1'b0;
    if_req   = 1'b0;
    observe();
    checkOutput("flush_req_aborted", bus_req, 1'b0);

    // Flush together with grant: response swallowed
    applyStimulus(1'b1, 32'h680, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    observe();
    @(negedge clk);
    bus_gnt  = 1'b1;
    if_flush = 1'b1;
    observe();
    @(negedge clk);
    bus_gnt    = 1'b0;
    if_flush   = 1'b0;
    if_req     = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h0000_BEEF;
    observe();
    checkOutput("flush_gnt_bus_req", bus_req, 1'b0);
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;

    // Flush in WAIT, response two cycles later
    applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    observe();
    @(negedge clk);
    bus_gnt = 1'b1;
    observe();
    checkOutput("flush_wait_addr", bus_addr, 32'h700);
    @(negedge clk);
    bus_gnt  = 1'b0;
    if_flush = 1'b1;
    observe();
    @(negedge clk);
    if_flush = 1'b0;
    if_req   = 1'b0;
    observe();
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h0000_0BAD;
    observe();
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;

    // A new fetch is served normally afterwards
    applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    observe();
    zeroWaitTxn(1'b0, 1'b0, 32'h800, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    observe();

    // Flush never touches a data transaction
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hB00, 32'h0000_0055, 4'h3);
    observe();
    zeroWaitTxn(1'b1, 1'b1, 32'hB00, 32'h0000_0055, 4'h3, 32'h0000_0077, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    observe();

    // Asynchronous reset in WAIT
    $display("[TB] async reset mid-transaction");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h900, 32'h0, 4'hF);
    observe();
    @(negedge clk);
    bus_gnt = 1'b1;
    observe();
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    checkOutput("arst_bus_req", bus_req, 1'b0);
    checkOutput("arst_bus_addr", bus_addr, 32'd0);
    checkOutput("arst_d_ack", d_ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    observe();
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h0000_1234;
    observe();
    checkOutput("arst_after_bus_req", bus_req, 1'b0);
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    // Timeout with no grant: d_ack and bus_err_o in the 8th REQ cycle
    $display("[TB] timeout");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'hA00, 32'h0, 4'hF);
    bus_rdata = 32'hFFFF_0000;
    observe();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 8) begin
        exp_err = 1'b1;
        sb.push_back('{1'b1, 32'h0});
      end
      observe();
      checkOutput("to_bus_req", bus_req, 1'b1);
    end
    checkOutput("to_ack_latency", sb.size(), 32'd0);
    @(negedge clk);
    exp_err = 1'b0;
    d_req   = 1'b0;
    observe();
    checkOutput("to_back_idle", bus_req, 1'b0);
    @(negedge clk);
    bus_rvalid = 1'b1;
    observe();
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
`endif

    @(negedge clk);
    observe();
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single unified memory bus between the instruction-fetch port and the data port (load/store, driven by the decoded mem_d_we / mem_d_wdsrc controls).
- Single outstanding transaction. Data has priority, with a starvation guard for fetch.
- Flushes on redirect abort or discard the in-flight fetch.
- Sits between the core pipeline and the memory/bus interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits (legal range 1..15).
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held high with stable if_addr until if_ack or if_flush.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  one-cycle pulse: discard the pending or in-flight fetch.
- if_ack  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held high with stable fields until d_ack.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  4  byte enables.
- d_ack  out  1  one-cycle pulse: access complete; d_rdata valid on loads.
- d_rdata  out  DATA_W  load data.
- bus_req  out  1  bus request; held until bus_gnt.
- bus_we  out  1  bus write enable.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_be  out  4  bus byte enables.
- bus_gnt  in  1  bus accepted the request this cycle.
- bus_rvalid  in  1  response valid (loads, fetches and store completions).
- bus_rdata  in  DATA_W  response data.
- bus_err_o  out  1  one-cycle pulse on timeout; tied 0 when the optional feature is disabled.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, owner = NONE, d_streak = 0, discard = 0.
  - All outputs 0.
  - A bus_rvalid arriving after reset deasserts is ignored while in IDLE.
- States: IDLE, REQ, WAIT.
- IDLE:
  - If d_req and (not if_req or d_streak < MAX_D_STREAK): owner = D.
  - Else if if_req and not if_flush: owner = I.
  - A winner is captured at the edge and the FSM moves to REQ. Bus fields are registered from the winner's inputs at that edge.
  - Stray bus_rvalid is ignored.
- d_streak update, at each grant:
  - Data grant while if_req is high: d_streak + 1, saturating.
  - Instruction grant: d_streak = 0.
  - Data grant with if_req low: d_streak = 0.
- REQ:
  - bus_req = 1 and bus fields are stable.
  - bus_gnt moves the FSM to WAIT.
  - if_flush with owner = I and no bus_gnt in the same cycle: abort to IDLE, no if_ack.
  - if_flush with owner = I and bus_gnt in the same cycle: go to WAIT with discard = 1.
- WAIT:
  - bus_req = 0.
  - On bus_rvalid: if discard = 0, the owner's ack pulses the same cycle (combinational pass-through); owner rdata = bus_rdata. If discard = 1, the response is swallowed with no ack.
  - The FSM then returns to IDLE and discard clears.
  - if_flush in WAIT with owner = I sets discard = 1. If if_flush and bus_rvalid coincide, the response is discarded.
- if_flush never affects a data transaction.
- Minimum latency: req at cycle 0, bus_req at cycle 1, gnt at cycle 1, rvalid at cycle 2, ack at cycle 2. One IDLE bubble follows each transaction (back-to-back throughput = 1 per 3 cycles with zero-wait memory).
- if_rdata / d_rdata are 0 whenever the corresponding ack is 0.
- Protocol errors are flagged by simulation assertions:
  - d_req dropping before d_ack.
  - if_req dropping before if_ack, unless if_flush.
  - bus_rvalid in REQ.

Optional Feature:
- Macro: MEM_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in REQ and WAIT and clears on entering IDLE.
  - Reaching TIMEOUT_CYCLES forces: owner ack pulse (unless discard), rdata = 0, bus_err_o pulse, return to IDLE.
  - A late bus_rvalid is then ignored.
- Undefined: no counter; bus_err_o is constant 0; the FSM can wait indefinitely.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, REQ, WAIT}.
  - arb_owner_t enum {NONE, I, D}.
  - Width constants BE_W = 4 and STREAK_W = 4.
- Sub-module mem_arb_watchdog holds the timeout counter, instantiated only under MEM_BUS_ARBITER_TIMEOUT_EN.

Test Plan:
- Single fetch, zero-wait: if_req with if_addr = 0x100; bus_gnt and bus_rvalid immediate with bus_rdata = 0xDEADBEEF -> bus_addr = 0x100 at cycle 1, if_ack with if_rdata = 0xDEADBEEF at cycle 2, nothing else.
- Simultaneous requests: if_req and d_req (store, d_addr = 0x2000, d_be = 0xF) at cycle 0 -> data served first with bus_we = 1; fetch granted in the following IDLE.
- Starvation, MAX_D_STREAK = 4: d_req held continuously plus if_req -> exactly 4 data grants, then 1 fetch grant, d_streak back to 0.
- Flush paths:
  - if_flush in REQ with bus_gnt low -> back to IDLE, no if_ack.
  - if_flush in WAIT, then bus_rvalid two cycles later -> no if_ack.
  - A new fetch is granted afterwards.
- Asynchronous reset in WAIT mid-transaction -> outputs 0 immediately; a subsequent bus_rvalid gives no ack.
- With MEM_BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, bus_gnt never asserted -> bus_err_o and d_ack pulse together at the 8th cycle after entering REQ, with d_rdata = 0.
